sequence_generator: RTL and testbench

- Serial pattern transmitter. It is the driving end of the serial bit stream that the sequence detector consumes.
- Loads a 1–8 bit pattern, shifts it out MSB-first on a single-bit line, one bit per BIT_DIV clocks, with optional continuous repeat.
- A 7-segment output shows the number of bits remaining, for on-board stimulus of the detector.

---
 rtl/sequence_generator.sv | 113 +++++++++++
 tb/tb_sequence_generator.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts a 1-8 bit pattern out MSB-first,
// one bit per BIT_DIV clocks, with optional repeat and a 7-seg countdown.
module sequence_generator #(
  parameter int unsigned BIT_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] pattern,
  input  logic [2:0] len,
  input  logic       rpt,
  input  logic       stop,
  output logic       x_out,
  output logic       bit_valid,
  output logic       busy,
  output logic       done,
  output logic [7:0] seg
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  localparam logic [7:0] DIV_MAX = 8'(BIT_DIV - 1);

  state_e     state_q;
  logic [7:0] pat_q;
  logic [2:0] len_q;
  logic       rpt_q;
  logic [2:0] bit_idx_q;
  logic [7:0] div_cnt_q;
  logic       stop_pend_q;
  logic       done_q;

  logic       bit_end;
  logic       again;

  assign bit_end = (div_cnt_q == DIV_MAX);
  // a stop seen on the final cycle still ends at this boundary
  assign again   = rpt_q && !stop_pend_q && !stop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      rpt_q       <= 1'b0;
      bit_idx_q   <= '0;
      div_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            pat_q       <= pattern;
            len_q       <= len;
            rpt_q       <= rpt;
            bit_idx_q   <= len;
            div_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
            state_q     <= SHIFT;
          end
        end
        SHIFT: begin
          if (stop) stop_pend_q <= 1'b1;
          if (!bit_end) begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end else begin
            div_cnt_q <= '0;
            if (bit_idx_q != 3'd0) begin
              bit_idx_q <= bit_idx_q - 3'd1;
            end else if (again) begin
              bit_idx_q <= len_q;
            end else begin
              state_q     <= IDLE;
              done_q      <= 1'b1;
              stop_pend_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q == SHIFT);
  assign bit_valid = busy;
  assign x_out     = busy ? pat_q[bit_idx_q] : 1'b1;
  assign done      = done_q;

  logic [6:0] digit;

  always_comb begin
    digit = 7'h00;
    unique case (bit_idx_q)
      3'd0: digit = 7'h06;
      3'd1: digit = 7'h5B;
      3'd2: digit = 7'h4F;
      3'd3: digit = 7'h66;
      3'd4: digit = 7'h6D;
      3'd5: digit = 7'h7D;
      3'd6: digit = 7'h07;
      3'd7: digit = 7'h7F;
      default: digit = 7'h00;
    endcase
  end

  assign seg = busy ? {rpt_q, digit} : 8'h40;

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: scoreboard of per-cycle expected outputs
// for two instances (BIT_DIV=1 and BIT_DIV=3) sharing one stimulus bus.
module tb_sequence_generator;

  typedef struct packed {
    logic       x;
    logic       bv;
    logic       busy;
    logic       done;
    logic [7:0] seg;
  } obs_t;

  localparam obs_t IDLE_O = '{x: 1'b1, bv: 1'b0, busy: 1'b0,
                              done: 1'b0, seg: 8'h40};
  localparam obs_t DONE_O = '{x: 1'b1, bv: 1'b0, busy: 1'b0,
                              done: 1'b1, seg: 8'h40};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pattern = '0;
  logic [2:0] len = '0;
  logic       rpt = 1'b0;
  logic       stop = 1'b0;

  logic       x1, bv1, busy1, done1;
  logic [7:0] seg1;
  logic       x3, bv3, busy3, done3;
  logic [7:0] seg3;

  int checks = 0;
  int errors = 0;

  obs_t exp_q[$];
  logic [7:0] dig [8] = '{8'h06, 8'h5B, 8'h4F, 8'h66,
                          8'h6D, 8'h7D, 8'h07, 8'h7F};

  sequence_generator #(.BIT_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern),
    .len(len), .rpt(rpt), .stop(stop), .x_out(x1),
    .bit_valid(bv1), .busy(busy1), .done(done1), .seg(seg1)
  );

  sequence_generator #(.BIT_DIV(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern),
    .len(len), .rpt(rpt), .stop(stop), .x_out(x3),
    .bit_valid(bv3), .busy(busy3), .done(done3), .seg(seg3)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t obs(input bit three);
    obs_t o;
    if (three) o = '{x: x3, bv: bv3, busy: busy3, done: done3, seg: seg3};
    else       o = '{x: x1, bv: bv1, busy: busy1, done: done1, seg: seg1};
    return o;
  endfunction

  function automatic void push_pass(input logic [7:0] p, input int l,
                                    input int div, input bit r);
    obs_t e;
    for (int i = l; i >= 0; i--) begin
      for (int d = 0; d < div; d++) begin
        e.x    = p[i];
        e.bv   = 1'b1;
        e.busy = 1'b1;
        e.done = 1'b0;
        e.seg  = {r, dig[i][6:0]};
        exp_q.push_back(e);
      end
    end
  endfunction

  function automatic void push_tx(input logic [7:0] p, input int l,
                                  input int div, input int passes,
                                  input bit r);
    for (int k = 0; k < passes; k++) push_pass(p, l, div, r);
    exp_q.push_back(DONE_O);
  endfunction

  task automatic wait_idle();
    int n = 0;
    start = 1'b0;
    stop  = 1'b0;
    rst   = 1'b0;
    while ((busy1 || busy3 || done1 || done3) && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles, need idle", n);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    obs_t o;
    pattern = 8'($urandom);
    len     = 3'($urandom);
    rpt     = 1'b1;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      o = obs(k[0]);
      checks++;
      if (o !== IDLE_O) begin
        errors++;
        $display("FAIL reset dut%0d: got %h need %h", k, o, IDLE_O);
      end
    end
    rst = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      o = obs(k[0]);
      checks++;
      if (o !== IDLE_O) begin
        errors++;
        $display("FAIL reset_release dut%0d: got %h need %h", k, o, IDLE_O);
      end
    end
  endtask

  task automatic test_basic();
    obs_t o, e;
    logic [7:0] rx = '0;
    int cyc = 1;
    wait_idle();
    push_tx(8'h06, 3, 1, 1, 1'b0);
    exp_q.push_back(IDLE_O);
    pattern = 8'h06; len = 3'd3; rpt = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    while (exp_q.size() > 0) begin
      o = obs(1'b0);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL basic cyc %0d: got %h need %h", cyc, o, e);
      end
      if (o.bv) rx = {rx[6:0], o.x};
      cyc++;
      step();
    end
    checks++;
    if (rx[3:0] !== 4'b0110) begin
      errors++;
      $display("FAIL basic_detect: got %b need 0110", rx[3:0]);
    end
  endtask

  task automatic test_divider();
    obs_t o, e;
    int cyc = 1;
    int nbusy = 0;
    wait_idle();
    push_tx(8'hA5, 7, 3, 1, 1'b0);
    exp_q.push_back(IDLE_O);
    pattern = 8'hA5; len = 3'd7; rpt = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    while (exp_q.size() > 0) begin
      o = obs(1'b1);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL divider cyc %0d: got %h need %h", cyc, o, e);
      end
      if (o.busy) nbusy++;
      cyc++;
      step();
    end
    checks++;
    if (nbusy != 24) begin
      errors++;
      $display("FAIL divider_busy: got %0d cycles need 24", nbusy);
    end
  endtask

  task automatic test_repeat_stop();
    obs_t o, e;
    int cyc = 1;
    wait_idle();
    stop = 1'b1;
    step();
    step();
    stop = 1'b0;
    push_tx(8'h03, 2, 1, 3, 1'b1);
    exp_q.push_back(IDLE_O);
    pattern = 8'h03; len = 3'd2; rpt = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    rpt = 1'b0;
    while (exp_q.size() > 0) begin
      o = obs(1'b0);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL repeat cyc %0d: got %h need %h", cyc, o, e);
      end
      stop = (cyc == 8);
      cyc++;
      step();
    end
  endtask

  task automatic test_len0();
    obs_t o, e;
    int cyc = 1;
    wait_idle();
    push_tx(8'h01, 0, 1, 1, 1'b0);
    exp_q.push_back(IDLE_O);
    pattern = 8'h01; len = 3'd0; rpt = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    while (exp_q.size() > 0) begin
      o = obs(1'b0);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL len0 cyc %0d: got %h need %h", cyc, o, e);
      end
      cyc++;
      step();
    end
  endtask

  task automatic test_start_mid_shift();
    obs_t o, e;
    int cyc = 1;
    wait_idle();
    push_tx(8'h5A, 7, 1, 1, 1'b0);
    exp_q.push_back(IDLE_O);
    pattern = 8'h5A; len = 3'd7; rpt = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    pattern = 8'hFF; len = 3'd1; rpt = 1'b1;
    while (exp_q.size() > 0) begin
      o = obs(1'b0);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL start_mid cyc %0d: got %h need %h", cyc, o, e);
      end
      start = (cyc == 3) || (cyc == 8);
      cyc++;
      step();
    end
    rpt = 1'b0;
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    int cyc = 1;
    wait_idle();
    push_pass(8'h06, 3, 1, 1'b0);
    exp_q.push_back(DONE_O);
    push_tx(8'h02, 1, 1, 1, 1'b0);
    exp_q.push_back(IDLE_O);
    pattern = 8'h06; len = 3'd3; rpt = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    while (exp_q.size() > 0) begin
      o = obs(1'b0);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL back_to_back cyc %0d: got %h need %h", cyc, o, e);
      end
      start = (cyc == 5);
      if (cyc == 5) begin
        pattern = 8'h02;
        len = 3'd1;
      end
      cyc++;
      step();
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    int cyc = 1;
    wait_idle();
    push_pass(8'hA5, 7, 1, 1'b0);
    exp_q = exp_q[0:2];
    exp_q.push_back(IDLE_O);
    exp_q.push_back(IDLE_O);
    pattern = 8'hA5; len = 3'd7; rpt = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    while (exp_q.size() > 0) begin
      o = obs(1'b0);
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid cyc %0d: got %h need %h", cyc, o, e);
      end
      rst = (cyc == 3);
      cyc++;
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    step();
    test_reset();
    test_basic();
    test_divider();
    test_repeat_stop();
    test_len0();
    test_start_mid_shift();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
